// File: rtl/qspi_mbox_pkg.sv
// Shared definitions for the mailbox engine: opcodes, slot layout, FSM states.
package qspi_mbox_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpMul  = 4'd2,
    OpAnd  = 4'd3,
    OpOr   = 4'd4,
    OpXor  = 4'd5,
    OpMinu = 4'd6,
    OpMaxu = 4'd7
  } opcode_e;

  // Byte offsets inside a channel slot
  localparam int unsigned OFS_CMD  = 0;
  localparam int unsigned OFS_STAT = 1;
  localparam int unsigned OFS_A    = 4;

  // Bit positions in CMD and STAT bytes
  localparam int unsigned CMD_GO_BIT    = 7;
  localparam int unsigned STAT_DONE_BIT = 0;
  localparam int unsigned STAT_ERR_BIT  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StPoll,
    StLdA,
    StLdB,
    StExec,
    StStRes,
    StStStat,
    StStCmd
  } state_e;

endpackage

// File: rtl/mbox_alu.sv
// Combinational integer ALU; results are modulo 2^OPND_W, opcodes 8..15 flag illegal.
module mbox_alu
  import qspi_mbox_pkg::*;
#(
  parameter int unsigned OPND_W = 32
) (
  input  logic [3:0]        opcode,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [OPND_W-1:0] res,
  output logic              illegal
);

  // Operation decode
  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (opcode)
      OpAdd:   res = a + b;
      OpSub:   res = a - b;
      OpMul:   res = a * b;
      OpAnd:   res = a & b;
      OpOr:    res = a | b;
      OpXor:   res = a ^ b;
      OpMinu:  res = (a < b) ? a : b;
      OpMaxu:  res = (a < b) ? b : a;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/qspi_mbox_engine.sv
// Round-robin mailbox engine on RAM port B: polls channel slots, loads operands
// byte-serially, executes one ALU op and writes result, status and cleared command.
module qspi_mbox_engine
  import qspi_mbox_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned OPND_W    = 32,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_BASE   = 0,
  parameter int unsigned CH_STRIDE = 16,
  parameter int unsigned RD_LAT    = 1,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              wen,
  output logic              busy,
  output logic              done,
  output logic [CH_W-1:0]   done_ch
);

  localparam int unsigned NBYTES = OPND_W / 8;
  localparam logic [ADDR_W-1:0] OFS_A_ADDR = ADDR_W'(OFS_A);
  localparam logic [ADDR_W-1:0] OFS_B_ADDR = ADDR_W'(OFS_A + NBYTES);
  localparam logic [ADDR_W-1:0] OFS_R_ADDR = ADDR_W'(OFS_A + 2 * NBYTES);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [1:0]        wait_q, wait_d;
  logic [3:0]        byte_q, byte_d;
  logic [3:0]        op_q, op_d;
  logic              err_q, err_d;
  logic [OPND_W-1:0] a_q, a_d;
  logic [OPND_W-1:0] b_q, b_d;
  logic [OPND_W-1:0] res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   done_ch_q, done_ch_d;

  logic [CH_W-1:0]   ch_next;
  logic [ADDR_W-1:0] slot_base;
  logic              rd_ready;
  logic              last_byte;
  logic [3:0]        alu_op;
  logic [OPND_W-1:0] alu_res;
  logic              alu_illegal;

  assign ch_next   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
  assign slot_base = ADDR_W'(CH_BASE) + ADDR_W'(ch_q) * ADDR_W'(CH_STRIDE);
  // data_in reflects the address held RD_LAT cycles earlier
  assign rd_ready  = (wait_q == 2'(RD_LAT));
  assign last_byte = (byte_q == 4'(NBYTES - 1));

  // During POLL the ALU decodes the incoming CMD byte to judge legality
  assign alu_op = (state_q == StPoll) ? data_in[3:0] : op_q;

  mbox_alu #(
    .OPND_W(OPND_W)
  ) u_alu (
    .opcode (alu_op),
    .a      (a_q),
    .b      (b_q),
    .res    (alu_res),
    .illegal(alu_illegal)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign done_ch = done_ch_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      wait_q    <= '0;
      byte_q    <= '0;
      op_q      <= '0;
      err_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      wait_q    <= wait_d;
      byte_q    <= byte_d;
      op_q      <= op_d;
      err_q     <= err_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
    end
  end

  // Next-state logic and RAM port-B outputs
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    wait_d    = wait_q;
    byte_d    = byte_q;
    op_d      = op_q;
    err_d     = err_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_ch_d = done_ch_q;
    addr      = '0;
    data_out  = '0;
    wen       = 1'b0;

    case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StPoll;
          wait_d  = '0;
        end
      end

      StPoll: begin
        addr = slot_base + ADDR_W'(OFS_CMD);
        if (!rd_ready) begin
          wait_d = wait_q + 2'd1;
        end else begin
          wait_d = '0;
          if (!data_in[CMD_GO_BIT]) begin
            ch_d    = ch_next;
            state_d = StIdle;
          end else begin
            op_d   = data_in[3:0];
            busy_d = 1'b1;
            byte_d = '0;
            if (alu_illegal) begin
              err_d   = 1'b1;
              state_d = StStStat;
            end else begin
              err_d   = 1'b0;
              state_d = StLdA;
            end
          end
        end
      end

      StLdA: begin
        addr = slot_base + OFS_A_ADDR + ADDR_W'(byte_q);
        if (!rd_ready) begin
          wait_d = wait_q + 2'd1;
        end else begin
          wait_d = '0;
          for (int k = 0; k < NBYTES; k++) begin
            if (byte_q == 4'(k)) a_d[8*k +: 8] = data_in;
          end
          if (last_byte) begin
            byte_d  = '0;
            state_d = StLdB;
          end else begin
            byte_d = byte_q + 4'd1;
          end
        end
      end

      StLdB: begin
        addr = slot_base + OFS_B_ADDR + ADDR_W'(byte_q);
        if (!rd_ready) begin
          wait_d = wait_q + 2'd1;
        end else begin
          wait_d = '0;
          for (int k = 0; k < NBYTES; k++) begin
            if (byte_q == 4'(k)) b_d[8*k +: 8] = data_in;
          end
          if (last_byte) begin
            byte_d  = '0;
            state_d = StExec;
          end else begin
            byte_d = byte_q + 4'd1;
          end
        end
      end

      StExec: begin
        res_d   = alu_res;
        byte_d  = '0;
        state_d = StStRes;
      end

      StStRes: begin
        addr = slot_base + OFS_R_ADDR + ADDR_W'(byte_q);
        wen  = 1'b1;
        for (int k = 0; k < NBYTES; k++) begin
          if (byte_q == 4'(k)) data_out = res_q[8*k +: 8];
        end
        if (last_byte) begin
          byte_d  = '0;
          state_d = StStStat;
        end else begin
          byte_d = byte_q + 4'd1;
        end
      end

      StStStat: begin
        addr                    = slot_base + ADDR_W'(OFS_STAT);
        wen                     = 1'b1;
        data_out[STAT_ERR_BIT]  = err_q;
        data_out[STAT_DONE_BIT] = ~err_q;
        state_d                 = StStCmd;
      end

      StStCmd: begin
        // Writing the opcode back with GO clear hands the slot to the host
        addr      = slot_base + ADDR_W'(OFS_CMD);
        wen       = 1'b1;
        data_out  = {4'b0000, op_q};
        busy_d    = 1'b0;
        done_d    = 1'b1;
        done_ch_d = ch_q;
        ch_d      = ch_next;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_qspi_mbox_engine.sv
// Self-checking bench: dual-port RAM model (host port + engine port B) and a
// behavioural model of the mailbox command semantics.
module tb_qspi_mbox_engine;

  localparam int RD_LAT = 1;
  localparam int STRIDE = 16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        wen;
  logic        busy;
  logic        done;
  logic [1:0]  done_ch;

  int checks = 0;
  int errors = 0;

  // RAM model
  logic [7:0] mem [0:255];
  logic [7:0] rd0, rd1;
  logic       h_we;
  logic [7:0] h_addr, h_data;

  logic [1:0] done_log [$];
  int         wr_cnt  = 0;
  int         bad_wen = 0;

  qspi_mbox_engine #(
    .ADDR_W   (32),
    .OPND_W   (32),
    .NUM_CH   (4),
    .CH_BASE  (0),
    .CH_STRIDE(STRIDE),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .wen     (wen),
    .busy    (busy),
    .done    (done),
    .done_ch (done_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (h_we) mem[h_addr] <= h_data;
    if (wen) mem[addr[7:0]] <= data_out;
    rd0 <= mem[addr[7:0]];
    rd1 <= rd0;
  end
  assign data_in = (RD_LAT == 1) ? rd0 : rd1;

  // Completion / write monitor
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (done) done_log.push_back(done_ch);
      if (wen) wr_cnt++;
      if (wen && !busy) bad_wen++;
    end
  end

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: begin p = 64'(a) * 64'(b); return p[31:0]; end
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return (a < b) ? a : b;
      4'd7: return (a > b) ? a : b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd32(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic host_wr(input int a, input logic [7:0] d);
    @(negedge clk);
    h_we = 1'b1; h_addr = 8'(a); h_data = d;
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic host_wr32(input int a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) host_wr(a + k, v[8*k +: 8]);
  endtask

  task automatic setup_slot(input int ch, input logic [7:0] cmd, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res_pre);
    host_wr32(ch*STRIDE + 4, a);
    host_wr32(ch*STRIDE + 8, b);
    host_wr32(ch*STRIDE + 12, res_pre);
    host_wr(ch*STRIDE + 1, 8'h00);
    host_wr(ch*STRIDE, cmd);
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_log.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  // Let the engine drain to IDLE with en low
  task automatic go_idle();
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(negedge clk);
    done_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b0; h_we = 1'b0; h_addr = '0; h_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", addr); end
    checks++; if (data_out !== 8'h0) begin errors++; $display("FAIL rst_dout got %h want 0", data_out); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rst_wen got %b want 0", wen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (done_ch !== 2'd0) begin errors++; $display("FAIL rst_done_ch got %0d want 0", done_ch); end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) host_wr(i, 8'h00);
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rst_idle_wr got %0d want 0", wr_cnt); end
  endtask

  task automatic test_add();
    bit ok;
    go_idle();
    setup_slot(0, 8'h80, 32'h3, 32'h5, 32'hA5A5_A5A5);
    en = 1'b1;
    wait_dones(1, 500, ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL add_timeout got 0 dones want 1"); end
    checks++; if (rd32(12) !== 32'h8) begin errors++; $display("FAIL add_res got %h want 00000008", rd32(12)); end
    checks++; if (mem[1] !== 8'h01) begin errors++; $display("FAIL add_stat got %h want 01", mem[1]); end
    checks++; if (mem[0] !== 8'h00) begin errors++; $display("FAIL add_cmd got %h want 00", mem[0]); end
    checks++; if (done_log.size() !== 1) begin errors++; $display("FAIL add_pulses got %0d want 1", done_log.size()); end
    checks++; if (ok && done_log[0] !== 2'd0) begin errors++; $display("FAIL add_ch got %0d want 0", done_log[0]); end
  endtask

  task automatic test_sub_mul();
    bit ok;
    go_idle();
    setup_slot(2, 8'h81, 32'h0, 32'h1, 32'h1234_5678);
    setup_slot(3, 8'h82, 32'h0001_0000, 32'h0001_0000, 32'h1234_5678);
    en = 1'b1;
    wait_dones(2, 800, ok);
    repeat (20) @(negedge clk);
    checks++; if (done_log.size() !== 2) begin errors++; $display("FAIL submul_pulses got %0d want 2", done_log.size()); end
    checks++; if (rd32(2*STRIDE+12) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_res got %h want ffffffff", rd32(2*STRIDE+12)); end
    checks++; if (rd32(3*STRIDE+12) !== 32'h0) begin errors++; $display("FAIL mul_res got %h want 00000000", rd32(3*STRIDE+12)); end
    checks++; if (mem[3*STRIDE] !== 8'h02) begin errors++; $display("FAIL mul_cmd got %h want 02", mem[3*STRIDE]); end
  endtask

  task automatic test_illegal();
    bit ok;
    go_idle();
    setup_slot(1, 8'h8C, 32'h11, 32'h22, 32'hDEAD_BEEF);
    en = 1'b1;
    wait_dones(1, 500, ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL ill_timeout got 0 dones want 1"); end
    checks++; if (mem[STRIDE+1] !== 8'h02) begin errors++; $display("FAIL ill_stat got %h want 02", mem[STRIDE+1]); end
    checks++; if (rd32(STRIDE+12) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ill_res got %h want deadbeef", rd32(STRIDE+12)); end
    checks++; if (mem[STRIDE] !== 8'h0C) begin errors++; $display("FAIL ill_cmd got %h want 0c", mem[STRIDE]); end
    checks++; if (done_ch !== 2'd1) begin errors++; $display("FAIL ill_done_ch_held got %0d want 1", done_ch); end
  endtask

  task automatic test_all_channels();
    bit ok;
    logic [3:0]  op [4];
    logic [31:0] a [4], b [4];
    go_idle();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      op[c] = 4'($urandom_range(0, 7)); a[c] = $urandom; b[c] = $urandom;
      setup_slot(c, {4'h8, op[c]}, a[c], b[c], 32'h0);
    end
    done_log.delete();
    en = 1'b1;
    wait_dones(4, 2000, ok);
    repeat (30) @(negedge clk);
    checks++; if (done_log.size() !== 4) begin errors++; $display("FAIL all_pulses got %0d want 4", done_log.size()); end
    for (int c = 0; c < 4 && c < done_log.size(); c++) begin
      checks++;
      if (done_log[c] !== 2'(c)) begin errors++; $display("FAIL all_order[%0d] got %0d want %0d", c, done_log[c], c); end
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rd32(c*STRIDE+12) !== ref_op(op[c], a[c], b[c])) begin
        errors++; $display("FAIL all_res[%0d] got %h want %h", c, rd32(c*STRIDE+12), ref_op(op[c], a[c], b[c]));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    logic [31:0] a, b;
    go_idle();
    a = $urandom; b = $urandom;
    setup_slot(0, 8'h80, a, b, 32'h0);
    en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (wen && addr == 32'd13) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmid_reach got 0 want 1"); end
    rst_n = 1'b0;
    #1;
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rmid_wen got %b want 0", wen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    done_log.delete();
    rst_n = 1'b1;
    wait_dones(1, 500, ok);
    repeat (10) @(negedge clk);
    checks++; if (!ok || done_log[0] !== 2'd0) begin errors++; $display("FAIL rmid_redo got %0d dones want 1 on ch0", done_log.size()); end
    checks++; if (rd32(12) !== a + b) begin errors++; $display("FAIL rmid_res got %h want %h", rd32(12), a + b); end
  endtask

  task automatic test_enable();
    bit ok, hit;
    int w0, first, other;
    logic [31:0] a [4], b [4];
    go_idle();
    a[1] = $urandom; b[1] = $urandom; a[2] = $urandom; b[2] = $urandom;
    setup_slot(1, 8'h80, a[1], b[1], 32'h0);
    setup_slot(2, 8'h85, a[2], b[2], 32'h0);
    w0 = wr_cnt;
    repeat (40) @(negedge clk);
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL en0_writes got %0d want %0d", wr_cnt, w0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en0_busy got %b want 0", busy); end
    en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clk); #1;
      if (busy && !wen && addr < 64 && addr[3:0] >= 4'd8 && addr[3:0] < 4'd12) hit = 1'b1;
    end
    en = 1'b0;
    checks++; if (!hit) begin errors++; $display("FAIL endrop_reach got 0 want 1"); end
    wait_dones(1, 500, ok);
    repeat (60) @(negedge clk);
    checks++; if (done_log.size() !== 1) begin errors++; $display("FAIL endrop_pulses got %0d want 1", done_log.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy got %b want 0", busy); end
    first = ok ? int'(done_log[0]) : 1;
    other = (first == 1) ? 2 : 1;
    checks++;
    if (rd32(first*STRIDE+12) !== ((first == 1) ? a[1] + b[1] : a[2] ^ b[2])) begin
      errors++; $display("FAIL endrop_res got %h want %h", rd32(first*STRIDE+12),
                         (first == 1) ? a[1] + b[1] : a[2] ^ b[2]);
    end
    checks++; if (mem[other*STRIDE][7] !== 1'b1) begin errors++; $display("FAIL endrop_pending got %h want GO set", mem[other*STRIDE]); end
    en = 1'b1;
    wait_dones(2, 500, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (rd32(other*STRIDE+12) !== ((other == 1) ? a[1] + b[1] : a[2] ^ b[2])) begin
      errors++; $display("FAIL enresume_res got %h want %h", rd32(other*STRIDE+12),
                         (other == 1) ? a[1] + b[1] : a[2] ^ b[2]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n, d, prev;
    logic [3:0]  mask;
    logic [3:0]  op [4];
    logic [31:0] a [4], b [4], pre [4], exp_res;
    bit seen [4];
    for (int r = 0; r < 8; r++) begin
      go_idle();
      mask = 4'($urandom_range(1, 15));
      n = 0;
      for (int c = 0; c < 4; c++) begin
        seen[c] = 1'b0;
        if (mask[c]) begin
          n++;
          op[c] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
          a[c] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
          b[c] = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
          pre[c] = $urandom;
          setup_slot(c, {4'h8, op[c]}, a[c], b[c], pre[c]);
        end
      end
      en = 1'b1;
      wait_dones(n, 2000, ok);
      repeat (30) @(negedge clk);
      checks++; if (done_log.size() !== n) begin errors++; $display("FAIL rnd%0d_pulses got %0d want %0d", r, done_log.size(), n); end
      prev = -1;
      for (int i = 0; i < done_log.size(); i++) begin
        d = (int'(done_log[i]) - int'(done_log[0]) + 4) % 4;
        checks++;
        if (!mask[done_log[i]] || seen[done_log[i]] || d <= prev) begin
          errors++; $display("FAIL rnd%0d_order[%0d] got ch %0d want unserviced ch after previous", r, i, done_log[i]);
        end
        seen[done_log[i]] = 1'b1;
        prev = d;
      end
      for (int c = 0; c < 4; c++) begin
        if (mask[c]) begin
          exp_res = op[c][3] ? pre[c] : ref_op(op[c], a[c], b[c]);
          checks++;
          if (rd32(c*STRIDE+12) !== exp_res || mem[c*STRIDE+1] !== (op[c][3] ? 8'h02 : 8'h01) ||
              mem[c*STRIDE] !== {4'h0, op[c]}) begin
            errors++; $display("FAIL rnd%0d_slot%0d got res %h stat %h cmd %h want res %h stat %h cmd %h",
                               r, c, rd32(c*STRIDE+12), mem[c*STRIDE+1], mem[c*STRIDE], exp_res,
                               op[c][3] ? 8'h02 : 8'h01, {4'h0, op[c]});
          end
        end
      end
    end
    checks++; if (bad_wen !== 0) begin errors++; $display("FAIL wen_outside_busy got %0d want 0", bad_wen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_illegal();
    test_all_channels();
    test_reset_mid();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
